// File: rtl/muldiv_ctrl_pkg.sv
// Shared constants, FSM state type and operand-signedness helpers for the RV32M
// multiply/divide controller. The divider is optional (macro RV32M_DIV_EN).
package muldiv_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [5:0] MD_ITER = 6'd32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  function automatic logic rs1_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iteration registers for the shift-add multiplier and, with RV32M_DIV_EN, the
// restoring divider. acc holds {high, low} product or {remainder, quotient}.
module muldiv_iter
  import muldiv_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              en_i,
`ifdef RV32M_DIV_EN
  input  logic              div_i,
`endif
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN:0]     add_s;
  logic [2*XLEN-1:0] mul_next_s;
`ifdef RV32M_DIV_EN
  logic              div_q;
  logic [XLEN:0]     trial_s;
  logic [XLEN:0]     diff_s;
`endif

  // One datapath step: multiplier adds on the low bit; divider shifts in the next dividend bit
  always_comb begin
    add_s      = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    mul_next_s = acc_q[0] ? {add_s, acc_q[XLEN-1:1]}
                          : {1'b0, acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1:1]};
    acc_d      = mul_next_s;
`ifdef RV32M_DIV_EN
    trial_s = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff_s  = trial_s - {1'b0, opnd_q};
    if (div_q) begin
      if (!diff_s[XLEN]) begin
        acc_d = {diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = {trial_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_d = mul_next_s;
    end
`endif
  end

  // Load operands on accept, then advance once per enabled cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= {(2*XLEN){1'b0}};
      opnd_q <= {XLEN{1'b0}};
`ifdef RV32M_DIV_EN
      div_q  <= 1'b0;
`endif
    end else if (load_i) begin
`ifdef RV32M_DIV_EN
      div_q  <= div_i;
      acc_q  <= {{XLEN{1'b0}}, (div_i ? a_i : b_i)};
      opnd_q <= div_i ? b_i : a_i;
`else
      acc_q  <= {{XLEN{1'b0}}, b_i};
      opnd_q <= a_i;
`endif
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M multi-cycle multiply/divide controller: stalls the pipeline, sequences
// muldiv_iter, applies sign fixup. Divide support is built only with RV32M_DIV_EN.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            id_ex_md_valid,
  input  logic [2:0]      id_ex_md_op,
  input  logic [XLEN-1:0] id_ex_rs1_data,
  input  logic [XLEN-1:0] id_ex_rs2_data,
  input  logic [4:0]      id_ex_rd_addr,
  input  logic            md_flush,
  output logic            md_stall,
  output logic            md_busy,
  output logic [XLEN-1:0] md_rd_data,
  output logic [4:0]      md_rd_addr,
  output logic            md_rd_wen
);

  md_state_e         state_q;
  logic [5:0]        cnt_q;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              neg_q;
  logic [XLEN-1:0]   rd_data_q;
  logic [4:0]        rd_addr_q;
  logic              accept_s;
  logic              a_neg_s;
  logic              b_neg_s;
  logic [XLEN-1:0]   a_mag_s;
  logic [XLEN-1:0]   b_mag_s;
  logic              special_s;
  logic [XLEN-1:0]   special_data_s;
  logic [XLEN-1:0]   fix_data_s;
  logic [2*XLEN-1:0] acc_s;
  logic [2*XLEN-1:0] prod_s;
`ifdef RV32M_DIV_EN
  logic              rem_neg_q;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
`endif

  // Accept decision plus operand signs and magnitudes for the unsigned datapath
  always_comb begin
    accept_s = (state_q == MD_IDLE) && id_ex_md_valid && !md_flush;
    a_neg_s  = rs1_signed(id_ex_md_op) && id_ex_rs1_data[XLEN-1];
    b_neg_s  = rs2_signed(id_ex_md_op) && id_ex_rs2_data[XLEN-1];
    a_mag_s  = a_neg_s ? -id_ex_rs1_data : id_ex_rs1_data;
    b_mag_s  = b_neg_s ? -id_ex_rs2_data : id_ex_rs2_data;
  end

  // Divide ops that bypass iteration and complete in one cycle
  always_comb begin
    special_s      = 1'b0;
    special_data_s = 32'd0;
`ifdef RV32M_DIV_EN
    if (id_ex_md_op[2]) begin
      if (id_ex_rs2_data == 32'd0) begin
        special_s      = 1'b1;
        special_data_s = id_ex_md_op[1] ? id_ex_rs1_data : 32'hFFFF_FFFF;
      end else if (rs2_signed(id_ex_md_op) && (id_ex_rs1_data == 32'h8000_0000) &&
                   (id_ex_rs2_data == 32'hFFFF_FFFF)) begin
        special_s      = 1'b1;
        special_data_s = id_ex_md_op[1] ? 32'd0 : 32'h8000_0000;
      end else begin
        special_s      = 1'b0;
      end
    end else begin
      special_s = 1'b0;
    end
`else
    special_s = id_ex_md_op[2];
`endif
  end

  // Sign fixup and result selection used in FIX
  always_comb begin
    prod_s = neg_q ? -acc_s : acc_s;
`ifdef RV32M_DIV_EN
    quo_s  = neg_q ? -acc_s[XLEN-1:0] : acc_s[XLEN-1:0];
    rem_s  = rem_neg_q ? -acc_s[2*XLEN-1:XLEN] : acc_s[2*XLEN-1:XLEN];
`endif
    case (op_q)
      MD_MUL:                       fix_data_s = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_data_s = prod_s[2*XLEN-1:XLEN];
`ifdef RV32M_DIV_EN
      MD_DIV, MD_DIVU:              fix_data_s = quo_s;
      MD_REM, MD_REMU:              fix_data_s = rem_s;
`endif
      default:                      fix_data_s = 32'd0;
    endcase
  end

  // Controller FSM with registered result and destination
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      cnt_q     <= 6'd0;
      op_q      <= 3'd0;
      rd_q      <= 5'd0;
      neg_q     <= 1'b0;
      rd_data_q <= 32'd0;
      rd_addr_q <= 5'd0;
`ifdef RV32M_DIV_EN
      rem_neg_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (accept_s) begin
            op_q  <= id_ex_md_op;
            rd_q  <= id_ex_rd_addr;
            neg_q <= a_neg_s ^ b_neg_s;
            cnt_q <= 6'd0;
`ifdef RV32M_DIV_EN
            rem_neg_q <= a_neg_s;
`endif
            if (special_s) begin
              rd_data_q <= special_data_s;
              rd_addr_q <= id_ex_rd_addr;
              state_q   <= MD_DONE;
            end else begin
              state_q <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          if (md_flush) begin
            state_q <= MD_IDLE;
          end else begin
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == (MD_ITER - 6'd1)) begin
              state_q <= MD_FIX;
            end
          end
        end
        MD_FIX: begin
          if (md_flush) begin
            state_q <= MD_IDLE;
          end else begin
            rd_data_q <= fix_data_s;
            rd_addr_q <= rd_q;
            state_q   <= MD_DONE;
          end
        end
        MD_DONE: state_q <= MD_IDLE;
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  muldiv_iter u_iter (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept_s && !special_s),
    .en_i   (state_q == MD_CALC),
`ifdef RV32M_DIV_EN
    .div_i  (id_ex_md_op[2]),
`endif
    .a_i    (a_mag_s),
    .b_i    (b_mag_s),
    .acc_o  (acc_s)
  );

  assign md_stall   = id_ex_md_valid && (state_q != MD_DONE);
  assign md_busy    = (state_q != MD_IDLE);
  assign md_rd_data = rd_data_q;
  assign md_rd_addr = rd_addr_q;
  assign md_rd_wen  = (state_q == MD_DONE) && (rd_addr_q != 5'd0) && !md_flush;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl; divide expectations follow RV32M_DIV_EN.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_ex_md_valid;
  logic [2:0]  id_ex_md_op;
  logic [31:0] id_ex_rs1_data;
  logic [31:0] id_ex_rs2_data;
  logic [4:0]  id_ex_rd_addr;
  logic        md_flush;
  logic        md_stall;
  logic        md_busy;
  logic [31:0] md_rd_data;
  logic [4:0]  md_rd_addr;
  logic        md_rd_wen;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .id_ex_md_valid (id_ex_md_valid),
    .id_ex_md_op    (id_ex_md_op),
    .id_ex_rs1_data (id_ex_rs1_data),
    .id_ex_rs2_data (id_ex_rs2_data),
    .id_ex_rd_addr  (id_ex_rd_addr),
    .md_flush       (md_flush),
    .md_stall       (md_stall),
    .md_busy        (md_busy),
    .md_rd_data     (md_rd_data),
    .md_rd_addr     (md_rd_addr),
    .md_rd_wen      (md_rd_wen)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Entered in an IDLE cycle; returns in the IDLE cycle after DONE with valid still driven.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                       input int lat);
    int early_wen;
    int bad_stall;
    int bad_busy;
    early_wen = 0;
    bad_stall = 0;
    bad_busy  = 0;
    id_ex_md_valid = 1'b1;
    id_ex_md_op    = op;
    id_ex_rs1_data = a;
    id_ex_rs2_data = b;
    id_ex_rd_addr  = rd;
    #1;
    check({tag, ":stall_accept"}, {31'd0, md_stall}, 32'd1);
    for (int c = 1; c < lat; c++) begin
      next_cycle();
      if (md_rd_wen !== 1'b0) early_wen++;
      if (md_stall !== 1'b1) bad_stall++;
      if (md_busy !== 1'b1) bad_busy++;
    end
    next_cycle();
    check({tag, ":wen"}, {31'd0, md_rd_wen}, {31'd0, (rd != 5'd0)});
    check({tag, ":data"}, md_rd_data, exp);
    check({tag, ":addr"}, {27'd0, md_rd_addr}, {27'd0, rd});
    check({tag, ":stall_done"}, {31'd0, md_stall}, 32'd0);
    check({tag, ":early_wen"}, 32'(early_wen), 32'd0);
    check({tag, ":stall_hold"}, 32'(bad_stall), 32'd0);
    check({tag, ":busy_hold"}, 32'(bad_busy), 32'd0);
    next_cycle();
    check({tag, ":idle_after"}, {30'd0, md_busy, md_rd_wen}, 32'd0);
    id_ex_md_valid = 1'b0;
  endtask

  initial begin
    int wen_seen;
    rst            = 1'b1;
    id_ex_md_valid = 1'b0;
    id_ex_md_op    = 3'd0;
    id_ex_rs1_data = 32'd0;
    id_ex_rs2_data = 32'd0;
    id_ex_rd_addr  = 5'd0;
    md_flush       = 1'b0;
    repeat (3) next_cycle();
    rst = 1'b0;
    #1;
    check("reset:stall", {31'd0, md_stall}, 32'd0);
    check("reset:busy", {31'd0, md_busy}, 32'd0);
    check("reset:wen", {31'd0, md_rd_wen}, 32'd0);
    check("reset:data", md_rd_data, 32'd0);
    check("reset:addr", {27'd0, md_rd_addr}, 32'd0);
    next_cycle();

    do_op("mul_7x-3",   MD_MUL,    32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34);
    do_op("mulh_min",   MD_MULH,   32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 34);
    do_op("mulhu_max",  MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 34);
    do_op("mulhsu_m1",  MD_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF, 34);
    do_op("mul_rd0",    MD_MUL,    32'd3,         32'd5,         5'd0,  32'd15,        34);
    do_op("mul_b2b",    MD_MUL,    32'h1234_5678, 32'd16,        5'd31, 32'h2345_6780, 34);

`ifdef RV32M_DIV_EN
    do_op("div_-7/2",   MD_DIV,    32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 34);
    do_op("rem_-7/2",   MD_REM,    32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 34);
    do_op("divu_100/7", MD_DIVU,   32'd100,       32'd7,         5'd12, 32'd14,        34);
    do_op("remu_100/7", MD_REMU,   32'd100,       32'd7,         5'd13, 32'd2,         34);
    do_op("divu_big",   MD_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         34);
    do_op("div_by0",    MD_DIV,    32'd5,         32'd0,         5'd15, 32'hFFFF_FFFF, 1);
    do_op("rem_by0",    MD_REM,    32'd5,         32'd0,         5'd16, 32'd5,         1);
    do_op("divu_by0",   MD_DIVU,   32'd5,         32'd0,         5'd17, 32'hFFFF_FFFF, 1);
    do_op("div_ovf",    MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 1);
    do_op("rem_ovf",    MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0,         1);
    do_op("divu_last",  MD_DIVU,   32'd100,       32'd7,         5'd12, 32'd14,        34);
    id_ex_md_op = MD_DIV;
`else
    do_op("div_off",    MD_DIV,    32'hFFFF_FFF9, 32'd2,         5'd10, 32'd0,         1);
    do_op("remu_off",   MD_REMU,   32'd100,       32'd7,         5'd13, 32'd0,         1);
    do_op("divu0_off",  MD_DIVU,   32'd5,         32'd0,         5'd15, 32'd0,         1);
    do_op("mul_last",   MD_MUL,    32'd2,         32'd7,         5'd12, 32'd14,        34);
    id_ex_md_op = MD_MUL;
`endif

    // Flush at cycle 10, then keep flushing while valid in IDLE: no accept, no write
    id_ex_md_valid = 1'b1;
    id_ex_rs1_data = 32'd100;
    id_ex_rs2_data = 32'd3;
    id_ex_rd_addr  = 5'd20;
    repeat (10) next_cycle();
    check("flush:busy_c10", {31'd0, md_busy}, 32'd1);
    md_flush = 1'b1;
    next_cycle();
    check("flush:idle_c11", {31'd0, md_busy}, 32'd0);
    next_cycle();
    check("flush:no_accept", {31'd0, md_busy}, 32'd0);
    md_flush       = 1'b0;
    id_ex_md_valid = 1'b0;
    wen_seen = 0;
    repeat (40) begin
      next_cycle();
      if (md_rd_wen !== 1'b0) wen_seen++;
    end
    check("flush:no_wen", 32'(wen_seen), 32'd0);
    check("flush:data_kept", md_rd_data, 32'd14);
    check("flush:addr_kept", {27'd0, md_rd_addr}, 32'd12);

    // Flush during DONE suppresses the strobe
    id_ex_md_valid = 1'b1;
    id_ex_md_op    = MD_MUL;
    id_ex_rs1_data = 32'd3;
    id_ex_rs2_data = 32'd4;
    id_ex_rd_addr  = 5'd21;
    repeat (34) next_cycle();
    md_flush = 1'b1;
    #1;
    check("flush_done:wen", {31'd0, md_rd_wen}, 32'd0);
    check("flush_done:data", md_rd_data, 32'd12);
    next_cycle();
    md_flush       = 1'b0;
    id_ex_md_valid = 1'b0;
    check("flush_done:idle", {31'd0, md_busy}, 32'd0);
    next_cycle();

    // Reset at cycle 20 of a MUL clears everything on the next edge
    id_ex_md_valid = 1'b1;
    id_ex_md_op    = MD_MUL;
    id_ex_rs1_data = 32'd7;
    id_ex_rs2_data = 32'hFFFF_FFFD;
    id_ex_rd_addr  = 5'd9;
    repeat (20) next_cycle();
    rst            = 1'b1;
    id_ex_md_valid = 1'b0;
    next_cycle();
    check("rst_mid:busy", {31'd0, md_busy}, 32'd0);
    check("rst_mid:wen", {31'd0, md_rd_wen}, 32'd0);
    check("rst_mid:data", md_rd_data, 32'd0);
    check("rst_mid:addr", {27'd0, md_rd_addr}, 32'd0);
    check("rst_mid:stall", {31'd0, md_stall}, 32'd0);
    rst = 1'b0;
    wen_seen = 0;
    repeat (40) begin
      next_cycle();
      if (md_rd_wen !== 1'b0) wen_seen++;
    end
    check("rst_mid:no_wen", 32'(wen_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle controller for the RV32M multiply/divide operations issued to the execute stage. It accepts one M-extension operation from ID/EX and freezes the pipeline through a stall signal. It sequences a one-bit-per-cycle shift-add/shift-subtract datapath, then returns the result, rd address and write enable to the regfile path alongside ex. It aborts cleanly on a pipeline flush.

## Interface
- XLEN, 32, operand/result width (only 32 is supported)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- id_ex_md_valid  in  1  an M-extension operation is present in EX; held stable by upstream while md_stall=1
- id_ex_md_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- id_ex_rs1_data  in  32  operand A
- id_ex_rs2_data  in  32  operand B
- id_ex_rd_addr  in  5  destination register
- md_flush  in  1  kill the in-flight operation (driven from ex_pc_pc_wen of an older redirect)
- md_stall  out  1  freeze PC/IF/ID/EX registers
- md_busy  out  1  FSM not in IDLE
- md_rd_data  out  32  result
- md_rd_addr  out  5  destination register
- md_rd_wen  out  1  one-cycle write strobe

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On id_ex_md_valid & !md_flush, latch the op, rd_addr, operand magnitudes and sign flags.
  - Signedness: op 001/100/110 treat both operands as signed; 010 treats only rs1 as signed.
  - Clear the 6-bit counter.
  - Go to CALC, except in the special divide cases below.
- CALC, multiply: one shift-add iteration per cycle into a 64-bit accumulator.
- CALC, divide: one restoring shift-subtract iteration per cycle, giving a 32-bit quotient and a 32-bit remainder.
- CALC exit: the counter increments each cycle; after the 32nd iteration (counter==31) go to FIX.
- FIX:
  - Multiply: negate the product if the operand signs differ.
  - Divide: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Select the result: MUL = low 32 bits; MULH/MULHSU/MULHU = high 32 bits; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register the result into md_rd_data, then go to DONE.
- DONE: md_rd_wen=1 iff md_rd_addr!=0, for exactly one cycle; return to IDLE.
- Special divide cases (decided in IDLE, go straight to DONE with the result loaded):
  - Divide by zero: quotient = 32'hFFFF_FFFF, remainder = rs1.
  - Signed overflow (rs1=32'h8000_0000, rs2=32'hFFFF_FFFF, op DIV/REM): quotient = 32'h8000_0000, remainder = 0.
- md_stall = id_ex_md_valid & (state != DONE). It is combinational and also high in the accept cycle.
- md_flush in CALC or FIX: next state IDLE, no write.
- md_flush in DONE: md_rd_wen forced to 0 that cycle, next state IDLE.
- md_flush in IDLE: no accept.
- md_rd_data and md_rd_addr hold their last values until the next FIX or special-case load.

## Timing
- Reset: state IDLE, counter 0; md_stall 0 (while valid=0), md_busy 0, md_rd_wen 0, md_rd_data 0, md_rd_addr 0.
- Normal op accepted at cycle 0: CALC cycles 1–32, FIX cycle 33, DONE cycle 34 (write strobe). md_stall is high in cycles 0–33.
- Special divide: accept at cycle 0, DONE at cycle 1.
- Back-to-back M ops: the cycle after DONE is IDLE and may accept the next op. There is a minimum 1-cycle IDLE gap between operations.
- Reset mid-operation: IDLE on the next edge; no write strobe; partial result discarded.

## Configuration
- RV32M_DIV_EN
  - Defined: all eight ops are supported as above.
  - Undefined: the divider datapath, remainder logic and special cases are compiled out. Ops 100–111 are accepted and go IDLE→DONE with md_rd_data=0 and a normal write strobe (1-cycle latency). Multiply is unchanged.

## Structure
- define.v gains:
  - op macros `MD_MUL … `MD_REMU (3-bit funct3 values)
  - state macros `MD_IDLE=2'd0, `MD_CALC=2'd1, `MD_FIX=2'd2, `MD_DONE=2'd3
  - `MD_ITER=6'd32
- Sub-module muldiv_iter:
  - Purely holds the accumulator/quotient/remainder registers.
  - Performs one iteration per enable, under control of muldiv_ctrl's FSM.
  - The FSM, counter, sign fixup and special cases stay in muldiv_ctrl.

## Test plan
- MUL rs1=7, rs2=-3 (32'hFFFF_FFFD) → md_rd_data=32'hFFFF_FFEB, md_rd_wen high at cycle 34 only, md_stall high cycles 0–33.
- MULH rs1=32'h8000_0000, rs2=32'h8000_0000 → 32'h4000_0000; MULHU 32'hFFFF_FFFF×32'hFFFF_FFFF → 32'hFFFF_FFFE; MULHSU rs1=-1, rs2=2 → 32'hFFFF_FFFF.
- DIV −7/2 → −3; REM −7/2 → −1; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV by 0 with rs1=5 → 32'hFFFF_FFFF at cycle 1; REM by 0 → 5; DIV 32'h8000_0000 / −1 → 32'h8000_0000, REM → 0.
- md_flush at cycle 10 of a DIV → IDLE at cycle 11, md_rd_wen never asserted. rst at cycle 20 of a MUL → all outputs 0 next cycle.
- MUL with rd_addr=0 → md_rd_wen stays 0 through DONE; next op accepted in the cycle after DONE.
